down_counter_tmr: RTL

//  Synchronous programmable down-counter / timer, the counting-down counterpart of our

---
 rtl/down_counter_tmr.sv | 84 ++++++++
 1 files changed

// File: rtl/down_counter_tmr.sv
// Programmable down-counter / timer.
// A load sets the start value and remembers it as the reload value. Each enabled
// clock then steps the count down by one, and a one-cycle terminal-count pulse
// is raised when the count reaches zero. In one-shot mode the counter stops at
// zero. In auto-reload mode it reloads on the next enabled cycle, so it divides
// the enable events by (D+1).
module down_counter_tmr #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             EC,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    input  logic             AR,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] rld_reg, rld_next;
    logic             tc_reg, tc_next;

    // State register: reset overrides everything; otherwise take the next-state values.
    always_ff @(posedge clk) begin
        if (r) begin
            state_reg <= IDLE;
            q_reg     <= CNT_ZERO;
            rld_reg   <= CNT_ZERO;
            tc_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            rld_reg   <= rld_next;
            tc_reg    <= tc_next;
        end
    end

    // Next-state logic: a load beats the count enable, and TC is a single-cycle pulse.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        rld_next   = rld_reg;
        tc_next    = 1'b0;
        if (ld) begin
            // A load of zero leaves nothing to count, so the counter stays idle.
            q_next     = D;
            rld_next   = D;
            state_next = (D != CNT_ZERO) ? RUN : IDLE;
        end else if (state_reg == RUN && EC) begin
            if (q_reg > CNT_ONE) begin
                q_next = q_reg - CNT_ONE;
            end else if (q_reg == CNT_ONE) begin
                // Terminal count. AR is only looked at here, so it may change freely
                // at any other time. One-shot mode drops busy in the same cycle that
                // Q shows zero.
                q_next  = CNT_ZERO;
                tc_next = 1'b1;
                if (!AR) begin
                    state_next = IDLE;
                end
            end else begin
                // The counter can be running at zero only in auto-reload mode. This
                // extra enabled cycle makes the period RLD+1 enabled cycles.
                q_next = rld_reg;
            end
        end
    end

    assign Q    = q_reg;
    assign TC   = tc_reg;
    assign busy = (state_reg == RUN);

endmodule
